// File: rtl/regfile_wb_writer_if.sv
// Writeback request channel from the datapath into the register-file writer.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_ready comes only from the writer's registered
// queue occupancy and never depends on req_valid in the same cycle. The
// datapath holds req_addr/req_data stable while req_valid is high and
// req_ready is low.
interface regfile_wb_writer_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_addr;
   logic [31:0] req_data;

   // Datapath side
   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   // Writer side
   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/regfile_wb_writer.sv
// Register-file write-port controller: in-order writeback queue, one
// registered write (enc/addrc/datac) per cycle, plus a bypass lookup over
// every write that has been accepted but not yet committed.
module regfile_wb_writer #(
   parameter int DEPTH      = 4,
   parameter bit DISCARD_R0 = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   regfile_wb_writer_if.slave       req_if,
   input  logic                     hold,
   output logic                     enc,
   output logic [4:0]               addrc,
   output logic [31:0]              datac,
   input  logic [4:0]               byp_addr,
   output logic                     byp_hit,
   output logic [31:0]              byp_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     idle
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    q_addr_q [DEPTH];
   logic [31:0]   q_data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          enc_q;
   logic [4:0]    addrc_q;
   logic [31:0]   datac_q;

   logic          drop;
   logic          push;
   logic          pop;
   logic          hit_d;
   logic [31:0]   hit_data_d;
   logic [PW-1:0] idx_d;

   // Ready is a pure function of occupancy so it cannot loop back through req_valid.
   assign req_if.req_ready = (count_q < CW'(DEPTH));

   // Writes to r0 complete the handshake but never occupy a queue slot.
   assign drop = DISCARD_R0 && (req_if.req_addr == 5'd0);
   assign push = req_if.req_valid && req_if.req_ready && !drop;
   assign pop  = (count_q != '0) && !hold;

   // Occupancy next-state: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue storage; contents are don't-care until count covers them, so no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         q_addr_q[wr_ptr_q] <= req_if.req_addr;
         q_data_q[wr_ptr_q] <= req_if.req_data;
      end
   end

   // Pointers, occupancy and the registered write-port stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         enc_q    <= 1'b0;
         addrc_q  <= 5'd0;
         datac_q  <= 32'd0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            enc_q    <= 1'b1;
            addrc_q  <= q_addr_q[rd_ptr_q];
            datac_q  <= q_data_q[rd_ptr_q];
         end else begin
            enc_q    <= 1'b0;
         end
      end
   end

   // Bypass search: output stage lowest priority, then queue oldest-to-youngest
   // so the youngest matching entry is the one left standing.
   always_comb begin
      hit_d      = 1'b0;
      hit_data_d = 32'd0;
      idx_d      = '0;
      if (enc_q && (addrc_q == byp_addr)) begin
         hit_d      = 1'b1;
         hit_data_d = datac_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx_d = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (q_addr_q[idx_d] == byp_addr)) begin
            hit_d      = 1'b1;
            hit_data_d = q_data_q[idx_d];
         end
      end
      if (DISCARD_R0 && (byp_addr == 5'd0)) begin
         hit_d      = 1'b0;
         hit_data_d = 32'd0;
      end
   end

   assign enc      = enc_q;
   assign addrc    = addrc_q;
   assign datac    = datac_q;
   assign byp_hit  = hit_d;
   assign byp_data = hit_data_d;
   assign count    = count_q;
   assign idle     = (count_q == '0) && !enc_q;
endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed bench for regfile_wb_writer: per-cycle vector table for the basic
// flows and bypass, hand-written sequences for back-pressure and reset flush,
// and a write-port scoreboard fed from the accepted requests.
module tb_regfile_wb_writer;
   logic        clock = 1'b0;
   logic        reset;
   logic        hold;
   logic        enc;
   logic [4:0]  addrc;
   logic [31:0] datac;
   logic [4:0]  byp_addr;
   logic        byp_hit;
   logic [31:0] byp_data;
   logic [2:0]  count;
   logic        idle;

   int n_vec = 0;
   int n_err = 0;

   logic [36:0] exp_q[$];

   regfile_wb_writer_if bus();

   regfile_wb_writer #(.DEPTH(4), .DISCARD_R0(1'b1)) dut (
      .clock    (clock),
      .reset    (reset),
      .req_if   (bus.slave),
      .hold     (hold),
      .enc      (enc),
      .addrc    (addrc),
      .datac    (datac),
      .byp_addr (byp_addr),
      .byp_hit  (byp_hit),
      .byp_data (byp_data),
      .count    (count),
      .idle     (idle)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard on the register-file write port: every enc=1 cycle must carry
   // the oldest outstanding accepted request.
   always @(negedge clock) begin
      if (!reset && enc === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected_write: actual addr=%0d data=0x%0h required=no write",
                     addrc, datac);
         end else begin
            chk("sb_write", {addrc, datac}, 32'(0) | {exp_q[0][36:32], exp_q[0][31:0]} >> 0);
            exp_q.pop_front();
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic [4:0] ba);
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.req_data  = d;
      hold          = h;
      byp_addr      = ba;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
      logic        h;
      logic [4:0]  ba;
      logic        rdy;
      logic        enc;
      logic [4:0]  ac;
      logic [31:0] dc;
      logic [2:0]  cnt;
      logic        hit;
      logic [31:0] bd;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                               input logic h, input logic [4:0] ba, input logic rdy,
                               input logic e, input logic [4:0] ac, input logic [31:0] dc,
                               input logic [2:0] cnt, input logic hit, input logic [31:0] bd);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.h = h; r.ba = ba; r.rdy = rdy;
      r.enc = e; r.ac = ac; r.dc = dc; r.cnt = cnt; r.hit = hit; r.bd = bd;
      return r;
   endfunction

   initial begin
      //             v  a   d             h  ba rdy enc ac  dc            cnt hit bd
      // single write after reset
      tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 1, 0, 0,  32'h0,        0, 0, 32'h0);
      tbl[1]  = mk(0, 0,  32'h0,        0, 5, 1, 0, 0,  32'h0,        1, 1, 32'hDEADBEEF);
      tbl[2]  = mk(0, 0,  32'h0,        0, 5, 1, 1, 5,  32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
      tbl[3]  = mk(0, 0,  32'h0,        0, 5, 1, 0, 5,  32'hDEADBEEF, 0, 0, 32'h0);
      // back-to-back stream 1..6
      tbl[4]  = mk(1, 1,  32'h10,       0, 0, 1, 0, 5,  32'hDEADBEEF, 0, 0, 32'h0);
      tbl[5]  = mk(1, 2,  32'h20,       0, 1, 1, 0, 5,  32'hDEADBEEF, 1, 1, 32'h10);
      tbl[6]  = mk(1, 3,  32'h30,       0, 1, 1, 1, 1,  32'h10,       1, 1, 32'h10);
      tbl[7]  = mk(1, 4,  32'h40,       0, 2, 1, 1, 2,  32'h20,       1, 1, 32'h20);
      tbl[8]  = mk(1, 5,  32'h50,       0, 4, 1, 1, 3,  32'h30,       1, 1, 32'h40);
      tbl[9]  = mk(1, 6,  32'h60,       0, 0, 1, 1, 4,  32'h40,       1, 0, 32'h0);
      tbl[10] = mk(0, 0,  32'h0,        0, 6, 1, 1, 5,  32'h50,       1, 1, 32'h60);
      tbl[11] = mk(0, 0,  32'h0,        0, 6, 1, 1, 6,  32'h60,       0, 1, 32'h60);
      tbl[12] = mk(0, 0,  32'h0,        0, 0, 1, 0, 6,  32'h60,       0, 0, 32'h0);
      // bypass priority under hold, then drain
      tbl[13] = mk(1, 3,  32'h11,       1, 0, 1, 0, 6,  32'h60,       0, 0, 32'h0);
      tbl[14] = mk(1, 7,  32'h22,       1, 3, 1, 0, 6,  32'h60,       1, 1, 32'h11);
      tbl[15] = mk(1, 3,  32'h33,       1, 3, 1, 0, 6,  32'h60,       2, 1, 32'h11);
      tbl[16] = mk(0, 0,  32'h0,        1, 3, 1, 0, 6,  32'h60,       3, 1, 32'h33);
      tbl[17] = mk(0, 0,  32'h0,        1, 7, 1, 0, 6,  32'h60,       3, 1, 32'h22);
      tbl[18] = mk(0, 0,  32'h0,        1, 9, 1, 0, 6,  32'h60,       3, 0, 32'h0);
      tbl[19] = mk(0, 0,  32'h0,        0, 3, 1, 0, 6,  32'h60,       3, 1, 32'h33);
      tbl[20] = mk(0, 0,  32'h0,        0, 3, 1, 1, 3,  32'h11,       2, 1, 32'h33);
      tbl[21] = mk(0, 0,  32'h0,        0, 3, 1, 1, 7,  32'h22,       1, 1, 32'h33);
      tbl[22] = mk(0, 0,  32'h0,        0, 3, 1, 1, 3,  32'h33,       0, 1, 32'h33);
      tbl[23] = mk(0, 0,  32'h0,        0, 3, 1, 0, 3,  32'h33,       0, 0, 32'h0);
      // r0 discard
      tbl[24] = mk(1, 0,  32'hFFFFFFFF, 0, 0, 1, 0, 3,  32'h33,       0, 0, 32'h0);
      tbl[25] = mk(0, 0,  32'h0,        0, 0, 1, 0, 3,  32'h33,       0, 0, 32'h0);
      tbl[26] = mk(0, 0,  32'h0,        0, 0, 1, 0, 3,  32'h33,       0, 0, 32'h0);
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Table: drive at negedge, check shortly after, apply at posedge.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].ba);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_enc", i),   32'(enc),           32'(tbl[i].enc));
         chk($sformatf("v%0d_addrc", i), 32'(addrc),         32'(tbl[i].ac));
         chk($sformatf("v%0d_datac", i), datac,              tbl[i].dc);
         chk($sformatf("v%0d_count", i), 32'(count),         32'(tbl[i].cnt));
         chk($sformatf("v%0d_idle", i),  32'(idle),
             32'((tbl[i].cnt == 3'd0) && !tbl[i].enc));
         chk($sformatf("v%0d_byp_hit", i),  32'(byp_hit), 32'(tbl[i].hit));
         chk($sformatf("v%0d_byp_data", i), byp_data,     tbl[i].bd);
         @(posedge clock);
         if (tbl[i].v && tbl[i].rdy && (tbl[i].a != 5'd0))
            exp_q.push_back({tbl[i].a, tbl[i].d});
         @(negedge clock);
      end

      // Fill under hold: four accepted, fifth stalls until a slot frees.
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(8 + i), 32'hA0 + 32'(i), 1, 0);
         #1;
         chk($sformatf("fill%0d_ready", i), 32'(bus.req_ready), 32'd1);
         @(posedge clock);
         exp_q.push_back({5'(8 + i), 32'hA0 + 32'(i)});
         @(negedge clock);
      end
      drive(1, 5'd12, 32'hA4, 1, 0);
      #1;
      chk("full_ready", 32'(bus.req_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      @(posedge clock);
      @(negedge clock);
      hold = 1'b0;
      #1;
      chk("release_ready", 32'(bus.req_ready), 32'd0);
      chk("release_count", 32'(count), 32'd4);
      chk("release_enc", 32'(enc), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("pop1_ready", 32'(bus.req_ready), 32'd1);
      chk("pop1_count", 32'(count), 32'd3);
      chk("pop1_enc", 32'(enc), 32'd1);
      chk("pop1_addrc", 32'(addrc), 32'd8);
      @(posedge clock);
      exp_q.push_back({5'd12, 32'hA4});
      @(negedge clock);
      bus.req_valid = 1'b0;
      for (int k = 9; k <= 12; k++) begin
         #1;
         chk($sformatf("drain%0d_enc", k), 32'(enc), 32'd1);
         chk($sformatf("drain%0d_addrc", k), 32'(addrc), 32'(k));
         @(posedge clock);
         @(negedge clock);
      end
      #1;
      chk("drained_enc", 32'(enc), 32'd0);
      chk("drained_idle", 32'(idle), 32'd1);

      // Reset flush: queued entries and the reset-cycle request are dropped.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         drive(1, 5'(20 + i), 32'hC0 + 32'(i), 1, 0);
         @(posedge clock);
      end
      @(negedge clock);
      #1;
      chk("prefl_count", 32'(count), 32'd3);
      drive(1, 5'd14, 32'h1414, 1, 0);
      reset = 1'b1;
      @(posedge clock);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      drive(0, 0, 0, 0, 14);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_enc", 32'(enc), 32'd0);
      chk("rst_addrc", 32'(addrc), 32'd0);
      chk("rst_datac", datac, 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_byp_hit", 32'(byp_hit), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("postrst_enc", 32'(enc), 32'd0);
      chk("postrst_idle", 32'(idle), 32'd1);
      drive(1, 5'd13, 32'h1313, 0, 0);
      @(posedge clock);
      exp_q.push_back({5'd13, 32'h1313});
      @(negedge clock);
      bus.req_valid = 1'b0;
      #1;
      chk("new_count", 32'(count), 32'd1);
      chk("new_enc0", 32'(enc), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("new_enc1", 32'(enc), 32'd1);
      chk("new_addrc", 32'(addrc), 32'd13);
      chk("new_datac", datac, 32'h1313);
      @(posedge clock);
      @(negedge clock);
      #1;
      chk("final_idle", 32'(idle), 32'd1);
      chk("sb_outstanding", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
